vector_normalize: RTL

//  Sequential normaliser: takes a vector::vector_t v and returns v/|v| with
//  |v| = sqrt(v.v). It maps a vector to a unit direction, the inverse

---
 rtl/fixed_point_pkg.sv | 22 ++
 rtl/vector_normalize_pkg.sv | 14 +
 rtl/vector_pkg.sv | 20 ++
 rtl/fixed_point_div_seq.sv | 52 +++++
 rtl/vector_dot_product.sv | 25 ++
 rtl/vector_normalize.sv | 126 ++++++++++++
 6 files changed

// File: rtl/fixed_point_pkg.sv
// Q16.16 signed fixed-point type, constants and a saturating magnitude helper.
package fixed_point;
  localparam int FP_WIDTH = 32;
  localparam int FP_FRAC  = 16;

  typedef logic signed [FP_WIDTH-1:0] fixed_point_t;

  localparam fixed_point_t FP_ONE = 32'sh0001_0000;
  localparam fixed_point_t FP_MIN = 32'sh8000_0000;
  localparam fixed_point_t FP_MAX = 32'sh7FFF_FFFF;

  // |v| with the most-negative code clamped to the largest positive value
  function automatic logic [FP_WIDTH-1:0] fp_abs_sat(input fixed_point_t v);
    if (v == FP_MIN) begin
      fp_abs_sat = FP_MAX;
    end else if (v[FP_WIDTH-1]) begin
      fp_abs_sat = ~v + 32'd1;
    end else begin
      fp_abs_sat = v;
    end
  endfunction
endpackage

// File: rtl/vector_normalize_pkg.sv
// Controller states and iteration counts for the vector normaliser.
package vector_normalize_pkg;
  import fixed_point::*;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DOT  = 3'd1,
    S_SQRT = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int SQRT_STEPS = (FP_WIDTH + FP_FRAC) / 2;
endpackage

// File: rtl/vector_pkg.sv
// Three-component fixed-point vector and axis selector used for per-axis sequencing.
package vector;
  import fixed_point::*;

  typedef struct packed {
    fixed_point_t x;
    fixed_point_t y;
    fixed_point_t z;
  } vector_t;

  typedef enum logic [1:0] {AXIS_X = 2'd0, AXIS_Y = 2'd1, AXIS_Z = 2'd2} axis_e;

  function automatic fixed_point_t vec_axis(input vector_t v, input axis_e a);
    case (a)
      AXIS_X:  vec_axis = v.x;
      AXIS_Y:  vec_axis = v.y;
      default: vec_axis = v.z;
    endcase
  endfunction
endpackage

// File: rtl/fixed_point_div_seq.sv
// Restoring divider, one quotient bit per cycle; the start cycle already performs step one.
module fixed_point_div_seq
  import fixed_point::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [FP_WIDTH+FP_FRAC-1:0] i_dividend,
  input  logic [FP_WIDTH-1:0]         i_divisor,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [FP_WIDTH-1:0]         o_quot
);
  localparam int HI = FP_WIDTH + FP_FRAC - FP_WIDTH;

  logic                r_busy;
  logic [5:0]          r_cnt;
  logic [FP_WIDTH-1:0] r_rem, r_lo, r_dsr;
  logic                w_load, w_ge;
  logic [FP_WIDTH-1:0] w_rem_src, w_lo_src, w_dsr_src;
  logic [FP_WIDTH:0]   w_sh;

  // dividend low bits shift out of r_lo while quotient bits shift in
  assign w_load    = i_start && !r_busy;
  assign w_rem_src = w_load ? {{(FP_WIDTH-HI){1'b0}}, i_dividend[FP_WIDTH+FP_FRAC-1:FP_WIDTH]} : r_rem;
  assign w_lo_src  = w_load ? i_dividend[FP_WIDTH-1:0] : r_lo;
  assign w_dsr_src = w_load ? i_divisor : r_dsr;
  assign w_sh      = {w_rem_src, w_lo_src[FP_WIDTH-1]};
  assign w_ge      = (w_sh >= {1'b0, w_dsr_src});
  assign o_quot    = {w_lo_src[FP_WIDTH-2:0], w_ge};
  assign o_done    = r_busy && (r_cnt == 6'd1);
  assign o_busy    = r_busy;

  // step engine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= 6'd0;
      r_rem  <= '0;
      r_lo   <= '0;
      r_dsr  <= '0;
    end else if (w_load || r_busy) begin
      r_rem  <= w_ge ? FP_WIDTH'(w_sh - {1'b0, w_dsr_src}) : w_sh[FP_WIDTH-1:0];
      r_lo   <= o_quot;
      r_dsr  <= w_dsr_src;
      r_cnt  <= w_load ? 6'(FP_WIDTH - 1) : r_cnt - 6'd1;
      r_busy <= w_load ? 1'b1 : (r_cnt != 6'd1);
    end else begin
      r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/vector_dot_product.sv
// Combinational Q16.16 dot product with signed-range overflow detection.
module vector_dot_product
  import fixed_point::*;
  import vector::*;
(
  input  vector_t      i_a,
  input  vector_t      i_b,
  output fixed_point_t o_dot,
  output logic         o_ovf
);
  localparam int PW = 2 * FP_WIDTH;
  localparam int SW = PW + 2;

  logic signed [PW-1:0] w_px, w_py, w_pz;
  logic signed [SW-1:0] w_sum, w_shr;

  assign w_px  = $signed(i_a.x) * $signed(i_b.x);
  assign w_py  = $signed(i_a.y) * $signed(i_b.y);
  assign w_pz  = $signed(i_a.z) * $signed(i_b.z);
  assign w_sum = SW'(w_px) + SW'(w_py) + SW'(w_pz);
  assign w_shr = w_sum >>> FP_FRAC;
  assign o_dot = w_shr[FP_WIDTH-1:0];
  // any bit above the sign position that is not a sign copy means the sum left Q16.16
  assign o_ovf = (w_shr[SW-1:FP_WIDTH-1] != {(SW-FP_WIDTH+1){w_shr[FP_WIDTH-1]}});
endmodule

// File: rtl/vector_normalize.sv
// Iterative normaliser: v.v, bit-serial sqrt, then three shared-divider passes giving v/|v|.
module vector_normalize
  import fixed_point::*;
  import vector::*;
  import vector_normalize_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  vector_t op,
  output logic    out_valid,
  input  logic    out_ready,
  output vector_t result,
  output logic    overflow,
  output logic    zero_vec
);
  state_e              r_state, w_state_nxt;
  vector_t             r_op, r_res;
  logic [47:0]         r_sq_n;
  logic [23:0]         r_sq_rem, r_sq_root, w_sq_root_nxt;
  logic [4:0]          r_sq_cnt;
  logic [FP_WIDTH-1:0] r_m;
  axis_e               r_axis;
  logic                r_in_ready, r_out_valid, r_ovf, r_zero;

  fixed_point_t        w_dot, w_c;
  logic                w_dot_ovf, w_accept, w_sq_ge, w_sq_last;
  logic [25:0]         w_sq_sh, w_sq_trial;
  logic                w_div_start, w_div_busy, w_div_done;
  logic [FP_WIDTH-1:0] w_quot, w_abs, w_mag, w_qfix;

  vector_dot_product u_dot (.i_a(r_op), .i_b(r_op), .o_dot(w_dot), .o_ovf(w_dot_ovf));

  fixed_point_div_seq u_div (
    .clk(clk), .rst(rst), .i_start(w_div_start),
    .i_dividend({w_abs, {FP_FRAC{1'b0}}}), .i_divisor(r_m),
    .o_busy(w_div_busy), .o_done(w_div_done), .o_quot(w_quot)
  );

  assign w_accept      = in_valid && r_in_ready;
  assign w_sq_sh       = {r_sq_rem, r_sq_n[47:46]};
  assign w_sq_trial    = {r_sq_root, 2'b01};
  assign w_sq_ge       = (w_sq_sh >= w_sq_trial);
  assign w_sq_root_nxt = {r_sq_root[22:0], w_sq_ge};
  assign w_sq_last     = (r_sq_cnt == 5'(SQRT_STEPS - 1));
  assign w_div_start   = (r_state == S_DIV) && !w_div_busy;
  assign w_c           = vec_axis(r_op, r_axis);
  assign w_abs         = fp_abs_sat(w_c);
  // truncated m can sit just below |c|; that quotient would exceed 1.0
  assign w_mag         = (w_abs >= r_m) ? FP_ONE : w_quot;
  assign w_qfix        = w_c[FP_WIDTH-1] ? (~w_mag + 32'd1) : w_mag;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_DOT; else w_state_nxt = S_IDLE;
      S_DOT:  if (w_dot_ovf) w_state_nxt = S_DONE; else w_state_nxt = S_SQRT;
      S_SQRT: begin
        if (w_sq_last) w_state_nxt = (w_sq_root_nxt == 24'd0) ? S_DONE : S_DIV;
        else           w_state_nxt = S_SQRT;
      end
      S_DIV:  if (w_div_done && (r_axis == AXIS_Z)) w_state_nxt = S_DONE; else w_state_nxt = S_DIV;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE; else w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // datapath and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op <= '0; r_res <= '0; r_sq_n <= '0; r_sq_rem <= '0; r_sq_root <= '0;
      r_sq_cnt <= 5'd0; r_m <= '0; r_axis <= AXIS_X;
      r_in_ready <= 1'b1; r_out_valid <= 1'b0; r_ovf <= 1'b0; r_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op <= op; r_res <= '0; r_ovf <= 1'b0; r_zero <= 1'b0; r_in_ready <= 1'b0;
        end
        S_DOT: begin
          r_sq_n    <= {w_dot, {FP_FRAC{1'b0}}};
          r_sq_rem  <= '0;
          r_sq_root <= '0;
          r_sq_cnt  <= 5'd0;
          if (w_dot_ovf) begin r_ovf <= 1'b1; r_out_valid <= 1'b1; end
        end
        S_SQRT: begin
          r_sq_n    <= {r_sq_n[45:0], 2'b00};
          r_sq_rem  <= w_sq_ge ? 24'(w_sq_sh - w_sq_trial) : w_sq_sh[23:0];
          r_sq_root <= w_sq_root_nxt;
          r_sq_cnt  <= r_sq_cnt + 5'd1;
          if (w_sq_last) begin
            r_m    <= {8'h00, w_sq_root_nxt};
            r_axis <= AXIS_X;
            if (w_sq_root_nxt == 24'd0) begin r_zero <= 1'b1; r_out_valid <= 1'b1; end
          end
        end
        S_DIV: if (w_div_done) begin
          case (r_axis)
            AXIS_X:  r_res.x <= w_qfix;
            AXIS_Y:  r_res.y <= w_qfix;
            default: r_res.z <= w_qfix;
          endcase
          if (r_axis == AXIS_Z)      r_out_valid <= 1'b1;
          else if (r_axis == AXIS_X) r_axis <= AXIS_Y;
          else                       r_axis <= AXIS_Z;
        end
        S_DONE: if (out_ready) begin r_out_valid <= 1'b0; r_in_ready <= 1'b1; end
        default: r_in_ready <= 1'b1;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_res;
  assign overflow  = r_ovf;
  assign zero_vec  = r_zero;
endmodule
